// File: rtl/crc16_cmd_sequencer.sv
// CRC-16 command-check sequencer: presets and steps an x^16+x^12+x^5+1 register per received bit,
// classifies the opcode prefix and issues a one-cycle verdict. Optional macro: CRC16_LEN_CHECK_EN.
module crc16_cmd_sequencer #(
  parameter logic [15:0] PRESET   = 16'hFFFF,
  parameter logic [15:0] RESIDUE  = 16'h1D0F,
  parameter int          MAX_BITS = 512,
  parameter int          CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             packet_start,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             packet_end,
  output logic             busy,
  output logic             done,
  output logic             needs_crc16,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             cmd_unsup,
  output logic             overflow,
  output logic [7:0]       opcode,
  output logic [CNT_W-1:0] bit_count,
  output logic [15:0]      crc_reg
);

  typedef enum logic [1:0] {IDLE, CLASSIFY, BODY, FINISH} state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BITS);

  state_e           state_q, state_d;
  logic [15:0]      crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       op_q, op_d;
  logic             needs_q, needs_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             unsup_q, unsup_d;
  logic             ovf_q, ovf_d;

  logic       in_frame;
  logic       accept;
  logic       fb;
  logic [2:0] op_idx;
  logic       len_ok;
  logic       crc_pass;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    needs_d  = needs_q;
    ok_d     = ok_q;
    err_d    = err_q;
    unsup_d  = unsup_q;
    ovf_d    = ovf_q;
    fb       = 1'b0;
    op_idx   = 3'd0;
    len_ok   = 1'b1;
    crc_pass = 1'b0;

    in_frame = (state_q == CLASSIFY) || (state_q == BODY);
    accept   = bit_valid && (packet_start || in_frame);

    // A start pulse wins in any state, silently abandoning a frame still in flight.
    if (packet_start) begin
      state_d = CLASSIFY;
      crc_d   = PRESET;
      cnt_d   = '0;
      op_d    = '0;
      needs_d = 1'b0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      unsup_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (state_q == FINISH) begin
      state_d = IDLE;
    end

    if (accept) begin
      if (cnt_d == MAX_CNT) begin
        ovf_d = 1'b1;
      end else begin
        fb    = bit_in ^ crc_d[15];
        crc_d = {crc_d[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        if (cnt_d < CNT_W'(8)) begin
          op_idx       = 3'd7 - cnt_d[2:0];
          op_d[op_idx] = bit_in;
        end
        cnt_d = cnt_d + 1'b1;
      end
    end

    if (state_d == CLASSIFY) begin
      if ((cnt_d == CNT_W'(2)) && !op_d[7]) begin
        needs_d = 1'b0;
        state_d = BODY;
      end else if (cnt_d == CNT_W'(4)) begin
        case (op_d[7:4])
          4'b1000, 4'b1001: needs_d = 1'b0;
          4'b1010, 4'b1100: needs_d = 1'b1;
          default:          unsup_d = 1'b1;
        endcase
        state_d = BODY;
      end
    end

    // The verdict uses the post-step values so a final bit riding with packet_end is included.
    if (packet_end && in_frame && !packet_start) begin
      if (state_d == CLASSIFY) unsup_d = 1'b1;
      state_d = FINISH;
`ifdef CRC16_LEN_CHECK_EN
      len_ok = (op_d == 8'hC1) ? (cnt_d == CNT_W'(40)) : (cnt_d >= CNT_W'(24));
`endif
      crc_pass = (crc_d == RESIDUE) && !ovf_d && len_ok;
      if (needs_d) begin
        ok_d  = crc_pass;
        err_d = !crc_pass;
      end else begin
        ok_d  = 1'b0;
        err_d = ovf_d;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      crc_q   <= PRESET;
      cnt_q   <= '0;
      op_q    <= '0;
      needs_q <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      unsup_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      needs_q <= needs_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      unsup_q <= unsup_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = (state_q == CLASSIFY) || (state_q == BODY);
  assign done        = (state_q == FINISH);
  assign needs_crc16 = needs_q;
  assign crc_ok      = ok_q;
  assign crc_err     = err_q;
  assign cmd_unsup   = unsup_q;
  assign overflow    = ovf_q;
  assign opcode      = op_q;
  assign bit_count   = cnt_q;
  assign crc_reg     = crc_q;

endmodule

// File: tb/tb_crc16_cmd_sequencer.sv
// Directed bench for crc16_cmd_sequencer: frames driven bit by bit, verdicts checked on the done cycle.
module tb_crc16_cmd_sequencer;
  localparam int BW = 600;

  logic       clk = 1'b0;
  logic       reset, packet_start, bit_valid, bit_in, packet_end;
  logic       busy, done, needs_crc16, crc_ok, crc_err, cmd_unsup, overflow;
  logic [7:0] opcode;
  logic [9:0] bit_count;
  logic [15:0] crc_reg;

  int n_vec    = 0;
  int n_miss   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  crc16_cmd_sequencer dut (
    .clk(clk), .reset(reset), .packet_start(packet_start), .bit_valid(bit_valid),
    .bit_in(bit_in), .packet_end(packet_end), .busy(busy), .done(done),
    .needs_crc16(needs_crc16), .crc_ok(crc_ok), .crc_err(crc_err), .cmd_unsup(cmd_unsup),
    .overflow(overflow), .opcode(opcode), .bit_count(bit_count), .crc_reg(crc_reg)
  );

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [BW-1:0] v, input int n);
    logic [15:0] c;
    logic        f;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      f = v[n-1-i] ^ c[15];
      c = {c[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Drives bits v[n-1..0] MSB-first; with end_frame the last bit rides with packet_end.
  task automatic drive_bits(input logic [BW-1:0] v, input int n, input int first, input bit end_frame);
    for (int i = first; i < n; i++) begin
      bit_valid  = 1'b1;
      bit_in     = v[n-1-i];
      packet_end = end_frame && (i == n - 1);
      tick();
    end
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    packet_end = 1'b0;
  endtask

  // Leaves the bench one cycle after the packet_end cycle, i.e. on the expected done cycle.
  task automatic send_frame(input string tag, input logic [BW-1:0] v, input int n, input bit merge);
    packet_start = 1'b1;
    bit_valid    = merge;
    bit_in       = merge ? v[n-1] : 1'b0;
    tick();
    packet_start = 1'b0;
    check({tag, ".busy"}, busy, 1'b1);
    drive_bits(v, n, merge ? 1 : 0, 1'b1);
    check({tag, ".done"}, done, 1'b1);
    check({tag, ".busy_fin"}, busy, 1'b0);
  endtask

  task automatic expect_verdict(input string tag, input logic needs, input logic ok,
                                input logic err, input logic unsup, input logic ovf);
    check({tag, ".needs"}, needs_crc16, needs);
    check({tag, ".ok"}, crc_ok, ok);
    check({tag, ".err"}, crc_err, err);
    check({tag, ".unsup"}, cmd_unsup, unsup);
    check({tag, ".ovf"}, overflow, ovf);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".done"}, done, 1'b0);
    expect_verdict(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, ".opcode"}, opcode, 8'h00);
    check({tag, ".count"}, bit_count, 10'd0);
    check({tag, ".crc"}, crc_reg, 16'hFFFF);
  endtask

  initial begin
    logic [BW-1:0] v, v_bad;
    logic [23:0]   d24;
    logic [31:0]   d32;
    logic [15:0]   c;
    int            d0;

    reset = 1'b1; packet_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; packet_end = 1'b0;
    tick(); tick();
    reset = 1'b0;
    expect_idle("reset");

    // Stray strobes while idle must not touch the register.
    bit_valid = 1'b1; bit_in = 1'b1; packet_end = 1'b1;
    tick();
    bit_valid = 1'b0; bit_in = 1'b0; packet_end = 1'b0;
    expect_idle("idle_ignore");

    // QueryRep, first bit shares the packet_start cycle.
    v = '0;
    send_frame("qrep", v, 4, 1'b1);
    expect_verdict("qrep", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("qrep.opcode", opcode, 8'h00);
    check("qrep.count", bit_count, 10'd4);
    tick();
    check("qrep.done_drop", done, 1'b0);
    check("qrep.count_hold", bit_count, 10'd4);

    // "123456789" through the register: CRC-16/CCITT-FALSE check value 0x29B1.
    v = '0; v[71:0] = 72'h31_32_33_34_35_36_37_38_39;
    send_frame("ascii", v, 72, 1'b0);
    check("ascii.crc", crc_reg, 16'h29B1);
    check("ascii.opcode", opcode, 8'h31);
    check("ascii.count", bit_count, 10'd72);
    expect_verdict("ascii", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // ReqRN with complemented CRC appended.
    d24 = {8'hC1, 16'hABCD};
    v = '0; v[23:0] = d24;
    c = crc_model(v, 24);
    v = '0; v[39:0] = {d24, ~c};
    send_frame("reqrn", v, 40, 1'b0);
    check("reqrn.crc", crc_reg, 16'h1D0F);
    check("reqrn.opcode", opcode, 8'hC1);
    check("reqrn.count", bit_count, 10'd40);
    expect_verdict("reqrn", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("reqrn.ok_hold", crc_ok, 1'b1);

    v_bad = v;
    v_bad[39-30] = ~v_bad[39-30];
    send_frame("reqrn_bad", v_bad, 40, 1'b0);
    expect_verdict("reqrn_bad", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    // Valid CRC but 48 bits: only the optional length check rejects it.
    d32 = {8'hC1, 16'hABCD, 8'h5A};
    v = '0; v[31:0] = d32;
    c = crc_model(v, 32);
    v = '0; v[47:0] = {d32, ~c};
    send_frame("reqrn48", v, 48, 1'b0);
    check("reqrn48.crc", crc_reg, 16'h1D0F);
`ifdef CRC16_LEN_CHECK_EN
    expect_verdict("reqrn48", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`else
    expect_verdict("reqrn48", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    tick();

    // Unsupported opcode 1011 plus 20 bits, then a 3-bit unclassifiable frame.
    v = '0; v[23:0] = {4'b1011, 20'hABCDE};
    send_frame("unsup", v, 24, 1'b0);
    expect_verdict("unsup", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("unsup.opcode", opcode, 8'hBA);
    tick();

    v = '0; v[2:0] = 3'b101;
    send_frame("short", v, 3, 1'b0);
    expect_verdict("short", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("short.opcode", opcode, 8'hA0);
    check("short.count", bit_count, 10'd3);
    tick();

    // Select stretched to MAX_BITS + 5.
    v = '0; v[516:513] = 4'b1010;
    send_frame("ovf", v, 517, 1'b0);
    expect_verdict("ovf", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("ovf.count", bit_count, 10'd512);
    tick();

    // Abort a Select frame with a fresh start, then run a good Select frame.
    d0 = done_cnt;
    packet_start = 1'b1;
    tick();
    packet_start = 1'b0;
    v = '0; v[9:0] = 10'b1010_000000;
    drive_bits(v, 10, 0, 1'b0);
    check("abort.busy", busy, 1'b1);
    check("abort.needs", needs_crc16, 1'b1);
    d24 = {8'hA5, 16'h1234};
    v = '0; v[23:0] = d24;
    c = crc_model(v, 24);
    v = '0; v[39:0] = {d24, ~c};
    send_frame("restart", v, 40, 1'b0);
    check("restart.no_early_done", done_cnt, d0);
    check("restart.crc", crc_reg, 16'h1D0F);
    check("restart.opcode", opcode, 8'hA5);
    check("restart.count", bit_count, 10'd40);
    expect_verdict("restart", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("restart.one_done", done_cnt, d0 + 1);

    // Reset in the middle of a frame.
    d0 = done_cnt;
    packet_start = 1'b1;
    tick();
    packet_start = 1'b0;
    v = '0; v[5:0] = 6'b101011;
    drive_bits(v, 6, 0, 1'b0);
    check("midrst.count_pre", bit_count, 10'd6);
    reset = 1'b1; packet_end = 1'b1;
    tick();
    reset = 1'b0; packet_end = 1'b0;
    expect_idle("midrst");
    tick();
    check("midrst.no_done", done_cnt, d0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/crc16_cmd_sequencer.md
Name: crc16_cmd_sequencer

Overview:
- Sequences CRC-16 checking of a received reader command on the tag: presets the CRC, feeds each demodulated bit, classifies the opcode, and issues a pass/fail verdict at end of frame.
- Contains its own CRC-16 register: polynomial x^16+x^12+x^5+1, MSB-first. This is the same recurrence used by the tag's standalone CRC-16 checker.
- Sits between the bit demodulator/framer and the command decoder. The decoder acts on `done` / `crc_ok`.

Parameters:
- PRESET, 16'hFFFF, CRC register preset at `packet_start`.
- RESIDUE, 16'h1D0F, register value that means a good frame after the transmitted CRC-16 has been shifted in.
- MAX_BITS, 512, maximum bits accepted per frame. Extra bits set overflow.
- CNT_W, 10, bit counter width. Must satisfy 2^CNT_W > MAX_BITS.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `packet_start` in 1: one-cycle pulse; a new frame begins.
- `bit_valid` in 1: one-cycle strobe; `bit_in` is valid.
- `bit_in` in 1: received data bit, MSB-first.
- `packet_end` in 1: one-cycle pulse; the frame is complete.
- `busy` out 1: high from `packet_start` until `done`.
- `done` out 1: one-cycle verdict pulse.
- `needs_crc16` out 1: the opcode class carries a CRC-16.
- `crc_ok` out 1: CRC-16 frame passed.
- `crc_err` out 1: CRC-16 frame failed, or overflow occurred.
- `cmd_unsup` out 1: opcode unsupported, or frame too short to classify.
- `overflow` out 1: more than MAX_BITS bits were received.
- `opcode` out 8: first 8 received bits, left-aligned; unreceived bits are 0.
- `bit_count` out CNT_W: bits accepted in the current frame.
- `crc_reg` out 16: live CRC register value.

Behaviour:
- Reset state (synchronous):
  - FSM in IDLE.
  - `crc_reg` = PRESET.
  - All flags, `opcode` and `bit_count` = 0.
- CRC step on each accepted bit:
  - fb = `bit_in` ^ `crc_reg`[15].
  - `crc_reg` <= {`crc_reg`[14:0], 1'b0} ^ (fb ? 16'h1021 : 0).
  - Every bit is included, opcode bits too.
- FSM states: IDLE, CLASSIFY, BODY, FINISH.
- IDLE:
  - `bit_valid` and `packet_end` are ignored.
  - On `packet_start`: `crc_reg` = PRESET; `bit_count`, `opcode` and result flags cleared; `busy` = 1; go to CLASSIFY.
  - If `bit_valid` is high in the same cycle as `packet_start`, that bit is the first bit, stepped from PRESET.
- CLASSIFY: accept bits and decide the class from the opcode prefix.
  - After 2 bits: 00 (QueryRep) or 01 (ACK) -> `needs_crc16` = 0; go to BODY.
  - After 4 bits:
    - 1000 (Query) and 1001 (QueryAdjust) -> `needs_crc16` = 0.
    - 1010 (Select) and 1100 (access group: ReqRN, Read, Write, SensData) -> `needs_crc16` = 1.
    - 1011, 1101, 1110, 1111 -> `cmd_unsup` = 1.
    - In all cases go to BODY.
- BODY: accept bits. `opcode` capture continues up to bit 8.
- Bit counting:
  - `bit_count` saturates at MAX_BITS.
  - A bit arriving when `bit_count` == MAX_BITS is dropped and sets `overflow` = 1.
- `packet_end` in CLASSIFY or BODY:
  - If `bit_valid` is high in the same cycle, that bit is accepted first.
  - Go to FINISH.
  - `packet_end` in CLASSIFY means the opcode was never classified: `cmd_unsup` = 1.
- FINISH (exactly one cycle, then IDLE):
  - `done` = 1, `busy` = 0.
  - If `needs_crc16`: `crc_ok` = (`crc_reg` == RESIDUE) & ~`overflow`, and `crc_err` = ~`crc_ok`.
  - Otherwise `crc_ok` = 0, and `crc_err` = `overflow`.
- Latency: `done` is asserted exactly 1 cycle after the `packet_end` cycle.
- Flag holding: verdict flags, `opcode` and `bit_count` hold until the next `packet_start` or `reset`.
- `packet_start` while busy: abort the current frame with no `done`, then restart as from IDLE.
- `reset` mid-frame: immediate return to reset state; no `done`.
- `reset` has priority over all other inputs.

Optional Feature:
- Macro: CRC16_LEN_CHECK_EN.
- When defined, FINISH also enforces frame length for CRC-16 classes; a failing length forces `crc_ok` = 0 and `crc_err` = 1:
  - opcode 11000001 (ReqRN): exactly 40 bits.
  - Other CRC-16 classes: at least 24 bits.
- When undefined: no length check; the verdict depends on residue and overflow only.

Test Plan:
1. QueryRep: `packet_start`, bits 0,0,0,0, `packet_end` -> `done` 1 cycle later; `needs_crc16` = 0, `crc_ok` = 0, `crc_err` = 0, `cmd_unsup` = 0, `opcode` = 8'h00, `bit_count` = 4.
2. ReqRN: bits 11000001, RN16 0xABCD, then the ones-complement CRC-16 of the first 24 bits from the bench model (40 bits total) -> `crc_reg` = 16'h1D0F, `crc_ok` = 1, `crc_err` = 0, `opcode` = 8'hC1.
3. Same ReqRN frame with bit 30 flipped -> `crc_ok` = 0, `crc_err` = 1. Then a frame with a valid CRC but 48 bits -> `crc_ok` = 1 without CRC16_LEN_CHECK_EN, `crc_err` = 1 with it.
4. Opcode 1011 + 20 bits -> `cmd_unsup` = 1 at `done`. A 3-bit frame 101 -> `cmd_unsup` = 1.
5. MAX_BITS + 5 bits of Select (1010…) -> `overflow` = 1, `bit_count` = 512, `crc_err` = 1.
6. Second `packet_start` in the middle of a Select frame -> no `done` for the first frame; the second frame is verified cleanly. `reset` asserted mid-frame -> all outputs 0, `crc_reg` = 16'hFFFF the next cycle.
